// File: rtl/mem_bus_responder.sv
// mem_bus_responder: decodes bus requests and runs timed async-SRAM accesses behind a four-phase request/ready handshake.
// Define MEM_BUS_RESPONDER_ERR_EN to add a sticky bus_err flag for simultaneous rd_n/wr_n requests.
module mem_bus_responder #(
    parameter int unsigned WAIT_STATES  = 2,
    parameter logic [15:0] DECODE_MASK  = 16'h8000,
    parameter logic [15:0] DECODE_MATCH = 16'h8000
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic [15:0] addr,
    input  logic [7:0]  bus_in,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    output logic        ready,
`ifdef MEM_BUS_RESPONDER_ERR_EN
    output logic        bus_err,
`endif
    output logic [15:0] sram_addr,
    input  logic [7:0]  sram_dq_in,
    output logic [7:0]  sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_rd_q, is_rd_d;
    logic [15:0] sram_addr_q, sram_addr_d;
    logic [7:0]  dq_out_q, dq_out_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;
    logic        ready_q, ready_d, bus_oe_q, bus_oe_d;
    logic        hit, valid;

    assign hit   = (addr & DECODE_MASK) == DECODE_MATCH;
    assign valid = hit && (rd_n ^ wr_n);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_rd_d     = is_rd_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        bus_out_d   = bus_out_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        dq_oe_d     = dq_oe_q;
        ready_d     = ready_q;
        bus_oe_d    = bus_oe_q;
        case (state_q)
            IDLE: if (valid) begin
                state_d     = SETUP;
                is_rd_d     = !rd_n;
                sram_addr_d = addr;
                dq_out_d    = bus_in;
                ce_n_d      = 1'b0;
                oe_n_d      = rd_n;
                dq_oe_d     = !wr_n;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_STATES);
                we_n_d  = is_rd_q;
            end
            ACCESS: if (cnt_q == 4'd0) begin
                state_d   = DONE;
                bus_out_d = is_rd_q ? sram_dq_in : bus_out_q;
                ce_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                we_n_d    = 1'b1;
                dq_oe_d   = 1'b0;
                ready_d   = 1'b1;
                bus_oe_d  = is_rd_q && !rd_n;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: begin
                // DONE: wait for both strobes to release before re-arming
                bus_oe_d = is_rd_q && !rd_n;
                if (rd_n && wr_n) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    bus_oe_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_rd_q     <= 1'b0;
            sram_addr_q <= 16'h0000;
            dq_out_q    <= 8'h00;
            bus_out_q   <= 8'h00;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            ready_q     <= 1'b0;
            bus_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_rd_q     <= is_rd_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            bus_out_q   <= bus_out_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            ready_q     <= ready_d;
            bus_oe_q    <= bus_oe_d;
        end
    end

`ifdef MEM_BUS_RESPONDER_ERR_EN
    logic err_q, err_d;

    assign err_d = err_q || (state_q == IDLE && hit && !rd_n && !wr_n);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign bus_err = err_q;
`endif

    assign bus_out     = bus_out_q;
    assign bus_oe      = bus_oe_q;
    assign ready       = ready_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
endmodule
